idli_sqi_ctrl_m: RTL and testbench
==================================

// Module: idli_sqi_ctrl_m
// PURPOSE
//  Sequences 16-bit word reads/writes to the external SQI SRAM over the core's 4-bit SQI memory pins.
//  Arbitrates between two requesters: fetch (F, read-only) and data (D, read/write).
//  Sits between the idli core pipeline and the o_core_mem_* / i_core_mem_sio pads.
//  SRAM is already in SQI + sequential mode when this block leaves reset; this block issues no mode commands.
// PARAMETERS
//  ADDR_W     16  word-address width; byte address = {(23-ADDR_W)'b0, addr, 1'b0}, sent as 24 bits
//  DUMMY_NIB  2   dummy nibbles between address and read data
//  GAP_CYC    1   min cycles CS held high between transactions (>=1)
// PORTS
//  i_sqi_gck           in   1       clock; single clock domain
//  i_sqi_rst           in   1       reset, synchronous, active-high
//  i_sqi_f_req         in   1       fetch request; hold with addr until ack
//  i_sqi_f_addr        in   ADDR_W  fetch word address
//  o_sqi_f_ack         out  1       1-cycle pulse: F request accepted and latched
//  o_sqi_f_vld         out  1       1-cycle pulse: o_sqi_f_data valid
//  o_sqi_f_data        out  16      fetched word; held until next F completion
//  i_sqi_d_req         in   1       data request; hold with wr/addr/wdata until ack
//  i_sqi_d_wr          in   1       1 = write, 0 = read
//  i_sqi_d_addr        in   ADDR_W  data word address
//  i_sqi_d_wdata       in   16      write data
//  o_sqi_d_ack         out  1       1-cycle pulse: D request accepted
//  o_sqi_d_vld         out  1       1-cycle pulse: read data valid, or write complete
//  o_sqi_d_rdata       out  16      read word; held until next D read completion
//  o_sqi_mem_sck       out  1       SQI clock, gck/2 while CS low, else 0
//  o_sqi_mem_cs        out  1       chip select, active-low
//  o_sqi_mem_io_mode   out  1       sqi_io_mode_t: 1 = drive (OUT), 0 = sample (IN)
//  o_sqi_mem_sio       out  4       nibble driven to SRAM
//  i_sqi_mem_sio       in   4       nibble from SRAM
//  o_sqi_busy          out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset (sync, takes effect next edge, also mid-transaction): FSM=IDLE, cs=1, sck=0, io_mode=OUT, sio=0,
//   all ack/vld=0, data regs=0, RR pointer=F; in-flight transaction dropped, no vld issued.
//  FSM: IDLE -> CMD(2 nib) -> ADDR(6 nib) -> [DUMMY(DUMMY_NIB) -> RDATA(4 nib)] | WDATA(4 nib) -> GAP -> IDLE.
//  Each nibble = 2 gck cycles: ph0 sck=0, sio updated; ph1 sck=1 (SRAM samples on rising sck).
//  Read nibbles captured from i_sqi_mem_sio on the gck edge ending ph1. All nibbles MSB first;
//   cmd 8'h03 read / 8'h02 write; word bits [15:12] first.
//  io_mode=IN from first DUMMY ph0 through end of RDATA; OUT otherwise. sio=0 whenever io_mode=IN or cs=1.
//  IDLE: if any req, grant one, pulse its ack combinationally, latch fields; cs falls next cycle.
//  Latency ack->vld: write 2*12+1 = 25 cycles, read 2*(12+DUMMY_NIB)+1 = 29 (default); vld pulses in first GAP cycle.
//  GAP: cs=1 for GAP_CYC cycles; no ack may pulse before GAP ends. Back-to-back issue: ack in cycle after GAP.
//  Arbitration (default, fixed priority): D beats F when both req in the same IDLE cycle.
//  Req deasserted before ack: no transaction; req arriving during busy waits, never lost while held.
//  Nibble counter 3 bits, wraps within each state; address high bits zero-padded per ADDR_W.
// CONFIGURATION
//  IDLI_SQI_RR_EN defined: round-robin; on simultaneous req, grant the port not granted last (pointer
//   resets to "F granted last", so first tie goes to D). Lone requester always granted.
//  Undefined: fixed priority D > F; no pointer flop.
// STRUCTURE
//  idli_pkg: sqi_io_mode_t {SQI_IO_IN=0, SQI_IO_OUT=1}; SQI_CMD_READ=8'h03, SQI_CMD_WRITE=8'h02;
//   sqi_ctrl_state_t enum {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, GAP}.
//  Sub-module idli_sqi_sreg_m: 16-bit nibble shift register, parallel load, shift-out MSB nibble, shift-in LSB.
//  Top holds FSM, nibble/phase counters, arbiter, output regs.
// TESTING
//  Reset: assert i_sqi_rst 3 cycles mid-ADDR -> next cycle cs=1, sck=0, io_mode=1, busy=0, no vld ever.
//  D write addr=16'h0012 data=16'hBEEF -> sio nibbles 0,2,0,0,0,0,2,4,B,E,E,F on rising sck; d_vld 25 cycles after ack.
//  F read addr=16'h0001 with model returning 16'hA5C3 -> cmd 0,3, addr 000002, 2 dummy, f_data=A5C3, f_vld at +29.
//  F and D req same cycle, fixed priority -> d_ack first; f_ack exactly 1 cycle after GAP ends.
//  IDLI_SQI_RR_EN: F,D held 4 transactions -> grants D,F,D,F; each ack one-hot.
//  Check cs high >= GAP_CYC between transactions; sck=0 and io_mode=OUT whenever cs=1.

Source files
------------

// File: rtl/idli_pkg.sv
// idli_pkg: shared SQI controller types and command constants.
package idli_pkg;
  typedef enum logic {SQI_IO_IN = 1'b0, SQI_IO_OUT = 1'b1} sqi_io_mode_t;
  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, GAP} sqi_ctrl_state_t;
endpackage

// File: rtl/idli_sqi_sreg_m.sv
// idli_sqi_sreg_m: 16-bit nibble shift register, parallel load, MSB nibble out, LSB nibble in.
module idli_sqi_sreg_m (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_data,
  input  logic        i_shift,
  input  logic [3:0]  i_nib,
  output logic [15:0] o_data
);
  logic [15:0] r_data;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_data <= '0;
    else if (i_load) r_data <= i_data;
    else if (i_shift) r_data <= {r_data[11:0], i_nib};
  end
  assign o_data = r_data;
endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: sequences 16-bit SQI SRAM reads/writes for fetch (F) and data (D) requesters.
// Define IDLI_SQI_RR_EN for round-robin arbitration; otherwise fixed priority D > F.
module idli_sqi_ctrl_m
  import idli_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DUMMY_NIB = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst,
  input  logic              i_sqi_f_req,
  input  logic [ADDR_W-1:0] i_sqi_f_addr,
  output logic              o_sqi_f_ack,
  output logic              o_sqi_f_vld,
  output logic [15:0]       o_sqi_f_data,
  input  logic              i_sqi_d_req,
  input  logic              i_sqi_d_wr,
  input  logic [ADDR_W-1:0] i_sqi_d_addr,
  input  logic [15:0]       i_sqi_d_wdata,
  output logic              o_sqi_d_ack,
  output logic              o_sqi_d_vld,
  output logic [15:0]       o_sqi_d_rdata,
  output logic              o_sqi_mem_sck,
  output logic              o_sqi_mem_cs,
  output logic              o_sqi_mem_io_mode,
  output logic [3:0]        o_sqi_mem_sio,
  input  logic [3:0]        i_sqi_mem_sio,
  output logic              o_sqi_busy
);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  sqi_ctrl_state_t   r_state, w_next;
  logic              r_ph, r_wr, r_port_d, r_f_vld, r_d_vld;
  logic [2:0]        r_nib, w_nib_max, w_idx;
  logic [GW-1:0]     r_gap;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_f_data, r_d_rdata, w_sreg;
  logic [31:0]       w_hdr;
  logic              w_idle, w_gnt_d, w_ack, w_active, w_last, w_shift, w_done;

  assign w_idle = (r_state == IDLE) && !i_sqi_rst;
  assign w_ack  = w_idle && (i_sqi_f_req || i_sqi_d_req);
`ifdef IDLI_SQI_RR_EN
  logic r_last_d;
  assign w_gnt_d = i_sqi_d_req && (!i_sqi_f_req || !r_last_d);
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) r_last_d <= 1'b0;
    else if (w_ack) r_last_d <= w_gnt_d;
  end
`else
  assign w_gnt_d = i_sqi_d_req;
`endif

  assign w_active  = !(r_state inside {IDLE, GAP});
  assign w_nib_max = (r_state == CMD) ? 3'd1 : (r_state == ADDR) ? 3'd5 :
                     (r_state == DUMMY) ? 3'(DUMMY_NIB - 1) : 3'd3;
  assign w_last    = r_ph && (r_nib == w_nib_max);
  assign w_shift   = r_ph && (r_state inside {RDATA, WDATA});
  assign w_done    = w_last && (r_state inside {RDATA, WDATA});

  idli_sqi_sreg_m u_sreg (
    .i_clk  (i_sqi_gck),
    .i_rst  (i_sqi_rst),
    .i_load (w_ack),
    .i_data (i_sqi_d_wdata),
    .i_shift(w_shift),
    .i_nib  (i_sqi_mem_sio),
    .o_data (w_sreg)
  );

  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         w_next = w_ack ? CMD : IDLE;
      CMD:          w_next = w_last ? ADDR : CMD;
      ADDR:         w_next = !w_last ? ADDR : r_wr ? WDATA : (DUMMY_NIB == 0) ? RDATA : DUMMY;
      DUMMY:        w_next = w_last ? RDATA : DUMMY;
      RDATA, WDATA: w_next = w_last ? GAP : r_state;
      GAP:          w_next = (r_gap == GW'(GAP_CYC - 1)) ? IDLE : GAP;
      default:      w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      r_ph      <= 1'b0;
      r_nib     <= '0;
      r_gap     <= '0;
      r_wr      <= 1'b0;
      r_port_d  <= 1'b0;
      r_addr    <= '0;
      r_f_vld   <= 1'b0;
      r_d_vld   <= 1'b0;
      r_f_data  <= '0;
      r_d_rdata <= '0;
    end else begin
      r_ph    <= w_active && !r_ph;
      r_nib   <= (!w_active || w_last) ? 3'd0 : r_ph ? r_nib + 3'd1 : r_nib;
      r_gap   <= (r_state == GAP) ? r_gap + GW'(1) : '0;
      r_f_vld <= w_done && !r_port_d;
      r_d_vld <= w_done && r_port_d;
      if (w_ack) begin
        r_wr     <= w_gnt_d && i_sqi_d_wr;
        r_port_d <= w_gnt_d;
        r_addr   <= w_gnt_d ? i_sqi_d_addr : i_sqi_f_addr;
      end
      // Final read nibble is taken straight from the pins, bypassing the shift register.
      if (w_done && !r_wr && !r_port_d) r_f_data <= {w_sreg[11:0], i_sqi_mem_sio};
      if (w_done && !r_wr && r_port_d) r_d_rdata <= {w_sreg[11:0], i_sqi_mem_sio};
    end
  end

  assign w_hdr = {r_wr ? SQI_CMD_WRITE : SQI_CMD_READ, 24'({r_addr, 1'b0})};
  assign w_idx = (r_state == ADDR) ? r_nib + 3'd2 : r_nib;

  always_comb begin
    o_sqi_f_ack       = w_idle && i_sqi_f_req && !w_gnt_d;
    o_sqi_d_ack       = w_idle && w_gnt_d;
    o_sqi_mem_cs      = !w_active;
    o_sqi_mem_sck     = w_active && r_ph;
    o_sqi_mem_io_mode = (r_state inside {DUMMY, RDATA}) ? SQI_IO_IN : SQI_IO_OUT;
    o_sqi_mem_sio     = (r_state inside {CMD, ADDR}) ? w_hdr[{3'd7 - w_idx, 2'b00} +: 4] :
                        (r_state == WDATA) ? w_sreg[15:12] : 4'h0;
    o_sqi_busy        = r_state != IDLE;
  end

  assign o_sqi_f_vld   = r_f_vld;
  assign o_sqi_d_vld   = r_d_vld;
  assign o_sqi_f_data  = r_f_data;
  assign o_sqi_d_rdata = r_d_rdata;
endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb_idli_sqi_ctrl_m: randomized self-checking bench with a pin-level SQI SRAM model and request-level reference.
module tb_idli_sqi_ctrl_m;
  localparam int DUMMY = 2;
  localparam int GAP = 1;
  localparam int LAT_WR = 2 * 12 + 1;
  localparam int LAT_RD = 2 * (12 + DUMMY) + 1;
`ifdef IDLI_SQI_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0, rst;
  logic f_req, f_ack, f_vld, d_req, d_wr, d_ack, d_vld;
  logic [15:0] f_addr, f_data, d_addr, d_wdata, d_rdata;
  logic sck, cs, io, busy;
  logic [3:0] sio_o, sio_i;

  idli_sqi_ctrl_m dut (
    .i_sqi_gck(clk), .i_sqi_rst(rst),
    .i_sqi_f_req(f_req), .i_sqi_f_addr(f_addr), .o_sqi_f_ack(f_ack), .o_sqi_f_vld(f_vld), .o_sqi_f_data(f_data),
    .i_sqi_d_req(d_req), .i_sqi_d_wr(d_wr), .i_sqi_d_addr(d_addr), .i_sqi_d_wdata(d_wdata),
    .o_sqi_d_ack(d_ack), .o_sqi_d_vld(d_vld), .o_sqi_d_rdata(d_rdata),
    .o_sqi_mem_sck(sck), .o_sqi_mem_cs(cs), .o_sqi_mem_io_mode(io), .o_sqi_mem_sio(sio_o),
    .i_sqi_mem_sio(sio_i), .o_sqi_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int pulses; int nout; logic [47:0] bits;} rec_t;
  typedef struct {bit wr; int addr; logic [15:0] data;} dreq_t;
  typedef struct {int ack; bit wr; logic [15:0] exp;} pend_t;

  int checks = 0, failures = 0, cyc = 0;
  rec_t recs[$], exps[$];
  dreq_t dq[$];
  int fq[$];
  pend_t fp[$], dp[$];
  logic [15:0] sram[int], ref_mem[int];
  bit tb_last_d;
  logic [3:0] g_hist;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic logic [15:0] sram_rd(int a);
    return sram.exists(a) ? sram[a] : init_word(a);
  endfunction

  // SQI SRAM model: samples pins on rising sck, answers reads, records every CS-low window.
  int p = 0, nout = 0, gapc = 0;
  bit in_txn = 1'b0;
  logic [47:0] bits = '0;
  logic [15:0] word;
  always @(negedge clk) begin
    if (cs === 1'b1) begin
      checks++;
      if (sck !== 1'b0 || io !== 1'b1 || sio_o !== 4'h0) begin
        failures++;
        $display("FAIL idle_pins sck=%b io=%b sio=%h required sck=0 io=1 sio=0", sck, io, sio_o);
      end
      if (in_txn) begin
        recs.push_back('{p, nout, bits});
        if (nout == 12 && p == 12 && bits[47:40] == 8'h02) sram[int'(bits[39:17])] = bits[15:0];
        in_txn = 1'b0;
      end
      gapc++;
    end else begin
      if (!in_txn) begin
        checks++;
        if (gapc < GAP) begin
          failures++;
          $display("FAIL cs_gap got=%0d required>=%0d", gapc, GAP);
        end
        in_txn = 1'b1; p = 0; nout = 0; bits = '0; gapc = 0;
      end
      if (io === 1'b0) begin
        checks++;
        if (sio_o !== 4'h0) begin
          failures++;
          $display("FAIL sio_in_mode got=%h required=0", sio_o);
        end
      end
      sio_i = 4'($urandom);
      if (sck === 1'b1) begin
        if (io === 1'b1) begin
          bits = {bits[43:0], sio_o};
          nout++;
        end else if (p >= 8 + DUMMY && p < 12 + DUMMY) begin
          word = sram_rd(int'(bits[23:1]));
          sio_i = word[4 * (11 + DUMMY - p) +: 4];
        end
        p++;
      end
    end
  end

  task automatic drive();
    f_req  = fq.size() > 0;
    f_addr = fq.size() > 0 ? 16'(fq[0]) : 16'($urandom);
    d_req  = dq.size() > 0;
    d_wr   = dq.size() > 0 ? dq[0].wr : 1'($urandom);
    d_addr = dq.size() > 0 ? 16'(dq[0].addr) : 16'($urandom);
    d_wdata = dq.size() > 0 ? dq[0].data : 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tb_last_d = 1'b0;
    recs.delete();
  endtask

  task automatic run(input int budget);
    int start = cyc, prev_ack = 0, prev_lat = 0, lat;
    bit prev_more = 1'b0, exp_d;
    dreq_t e;
    pend_t x;
    int fa;
    @(posedge clk);
    #1 drive();
    while ((fq.size() + dq.size() + fp.size() + dp.size()) > 0 && cyc - start < budget) begin
      @(negedge clk);
      checks++;
      if (f_ack && d_ack) begin
        failures++;
        $display("FAIL ack_onehot f_ack=%b d_ack=%b required one-hot", f_ack, d_ack);
      end
      if (f_ack || d_ack) begin
        exp_d = d_req && (!f_req || !RR || !tb_last_d);
        checks++;
        if (d_ack !== exp_d) begin
          failures++;
          $display("FAIL grant d_ack=%b required=%b", d_ack, exp_d);
        end
        if (prev_more) begin
          checks++;
          if (cyc - prev_ack != prev_lat + GAP) begin
            failures++;
            $display("FAIL ack_spacing got=%0d required=%0d", cyc - prev_ack, prev_lat + GAP);
          end
        end
        if (d_ack) begin
          e = dq.pop_front();
          lat = e.wr ? LAT_WR : LAT_RD;
          if (e.wr) ref_mem[e.addr] = e.data;
          dp.push_back('{cyc, e.wr, e.wr ? 16'h0 : ref_rd(e.addr)});
          exps.push_back(e.wr ? '{12, 12, {8'h02, 24'(e.addr * 2), e.data}}
                              : '{12 + DUMMY, 8, {16'h0, 8'h03, 24'(e.addr * 2)}});
        end else begin
          fa = fq.pop_front();
          lat = LAT_RD;
          fp.push_back('{cyc, 1'b0, ref_rd(fa)});
          exps.push_back('{12 + DUMMY, 8, {16'h0, 8'h03, 24'(fa * 2)}});
        end
        g_hist = {g_hist[2:0], d_ack};
        tb_last_d = d_ack;
        prev_ack = cyc; prev_lat = lat; prev_more = (fq.size() + dq.size()) > 0;
      end
      if (f_vld) begin
        checks++;
        if (fp.size() == 0) begin
          failures++;
          $display("FAIL f_vld_spurious got=1 required=0");
        end else begin
          x = fp.pop_front();
          if (cyc - x.ack != LAT_RD || f_data !== x.exp) begin
            failures++;
            $display("FAIL f_read lat=%0d data=%h required lat=%0d data=%h", cyc - x.ack, f_data, LAT_RD, x.exp);
          end
        end
      end
      if (d_vld) begin
        checks++;
        if (dp.size() == 0) begin
          failures++;
          $display("FAIL d_vld_spurious got=1 required=0");
        end else begin
          x = dp.pop_front();
          if (cyc - x.ack != (x.wr ? LAT_WR : LAT_RD) || (!x.wr && d_rdata !== x.exp)) begin
            failures++;
            $display("FAIL d_txn wr=%b lat=%0d data=%h required lat=%0d data=%h", x.wr, cyc - x.ack, d_rdata,
                     x.wr ? LAT_WR : LAT_RD, x.exp);
          end
        end
      end
      @(posedge clk);
      #1 drive();
    end
    if (cyc - start >= budget) begin
      checks++; failures++;
      $display("FAIL run_timeout pending f=%0d d=%0d required 0", fq.size() + fp.size(), dq.size() + dp.size());
      fq.delete(); dq.delete(); fp.delete(); dp.delete();
      drive();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (recs.size() != exps.size()) begin
      failures++;
      $display("FAIL pin_txn_count got=%0d required=%0d", recs.size(), exps.size());
    end
    while (recs.size() > 0 && exps.size() > 0) begin
      rec_t r = recs.pop_front(), q = exps.pop_front();
      checks++;
      if (r.pulses != q.pulses || r.nout != q.nout || r.bits !== q.bits) begin
        failures++;
        $display("FAIL pin_stream pulses=%0d nout=%0d bits=%h required pulses=%0d nout=%0d bits=%h",
                 r.pulses, r.nout, r.bits, q.pulses, q.nout, q.bits);
      end
    end
    recs.delete(); exps.delete();
  endtask

  task automatic test_reset();
    int nv = 0, bad = 0, w = 0;
    drive();
    do_reset();
    @(negedge clk);
    checks++;
    if (cs !== 1 || sck !== 0 || io !== 1 || busy !== 0 || f_ack !== 0 || d_ack !== 0 || f_vld !== 0 ||
        d_vld !== 0 || f_data !== 0 || d_rdata !== 0) begin
      failures++;
      $display("FAIL reset_state cs=%b sck=%b io=%b busy=%b fd=%h dd=%h required 1 0 1 0 0000 0000",
               cs, sck, io, busy, f_data, d_rdata);
    end
    @(posedge clk);
    #1 begin d_req = 1; d_wr = 1; d_addr = 16'h0012; d_wdata = 16'hBEEF; end
    @(negedge clk);
    while (!d_ack && w < 5) begin @(negedge clk); w++; end
    checks++;
    if (!d_ack) begin
      failures++;
      $display("FAIL reset_setup_ack got=0 required=1");
    end
    @(posedge clk);
    #1 d_req = 0;
    repeat (8) @(posedge clk);
    #1 rst = 1;
    checks++;
    if (cs !== 0 || busy !== 1) begin
      failures++;
      $display("FAIL mid_addr cs=%b busy=%b required cs=0 busy=1", cs, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (cs !== 1 || sck !== 0 || io !== 1 || busy !== 0 || d_ack !== 0 || f_ack !== 0) begin
      failures++;
      $display("FAIL reset_abort cs=%b sck=%b io=%b busy=%b required 1 0 1 0", cs, sck, io, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nv += f_vld + d_vld;
      bad += (cs !== 1) || busy;
    end
    checks++;
    if (nv != 0 || bad != 0) begin
      failures++;
      $display("FAIL reset_no_vld vld=%0d active=%0d required 0 0", nv, bad);
    end
    recs.delete();
    tb_last_d = 1'b0;
  endtask

  task automatic test_write();
    dq.push_back('{1'b1, 16'h0012, 16'hBEEF});
    run(200);
  endtask

  task automatic test_read();
    sram[1] = 16'hA5C3;
    ref_mem[1] = 16'hA5C3;
    fq.push_back(1);
    run(200);
  endtask

  task automatic test_priority();
    dq.push_back('{1'($urandom), int'($urandom_range(0, 15)), 16'($urandom)});
    fq.push_back(int'($urandom_range(0, 15)));
    run(300);
  endtask

  task automatic test_back_to_back();
    do_reset();
    g_hist = '0;
    for (int i = 0; i < 2; i++) begin
      dq.push_back('{1'($urandom), int'($urandom_range(0, 15)), 16'($urandom)});
      fq.push_back(int'($urandom_range(0, 15)));
    end
    run(600);
    checks++;
    if (g_hist !== (RR ? 4'b1010 : 4'b1100)) begin
      failures++;
      $display("FAIL grant_order got=%b required=%b (1=D)", g_hist, RR ? 4'b1010 : 4'b1100);
    end
  endtask

  task automatic test_req_drop();
    int nf = 0, nv = 0, w = 0;
    @(posedge clk);
    #1 begin d_req = 1; d_wr = 1; d_addr = 16'h0033; d_wdata = 16'h1234; f_req = 0; end
    @(negedge clk);
    while (!d_ack && w < 5) begin @(negedge clk); w++; end
    ref_mem[16'h0033] = 16'h1234;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1 begin d_req = 0; f_req = (i >= 5 && i < 8); end
      @(negedge clk);
      nf += f_ack;
      nv += d_vld;
    end
    checks++;
    if (nf != 0 || nv != 1) begin
      failures++;
      $display("FAIL req_drop f_ack=%0d d_vld=%0d required 0 1", nf, nv);
    end
    recs.delete();
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        int a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 7));
        if ($urandom_range(0, 1)) fq.push_back(a);
        else dq.push_back('{1'($urandom), a, 16'($urandom)});
      end
      run(1500);
    end
  endtask

  initial begin
    rst = 1'b1;
    f_req = 0; d_req = 0; d_wr = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
    tb_last_d = 1'b0;
    g_hist = '0;
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_back_to_back();
    test_req_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
